// File: rtl/rx_mac.sv
// GMII receive MAC: strips preamble/SFD, streams N+1 payload bytes, checks the trailing CRC-32 FCS.
// Inputs and outputs are each registered once; the payload stream has no backpressure.
module rx_mac #(
  parameter int MIN_FRAME_LENGTH = 64,
  parameter int MAX_FRAME_LENGTH = 1518,
  parameter int MIN_PREAMBLE     = 5
) (
  input  logic       RX_CLK,
  input  logic       SYS_RST,
  input  logic [7:0] GMII_RXD,
  input  logic       GMII_RX_DV,
  input  logic       GMII_RX_ER,
  output logic       RX_BUSY,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  output logic       RX_SOF,
  output logic       RX_EOF,
  output logic [7:0] RX_LEN,
  output logic       RX_DONE,
  output logic       RX_CRC_OK,
  output logic [3:0] RX_ERR
);

  localparam logic [10:0] RUNT_BYTES = 11'(MIN_FRAME_LENGTH - 8);
  localparam logic [10:0] MAX_BYTES  = 11'(MAX_FRAME_LENGTH);
  localparam logic [3:0]  MIN_PRE    = 4'(MIN_PREAMBLE);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_CNTRL, S_PAYLOAD, S_PAD, S_DROP, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  rxd_q;
  logic        dv_q, er_q, dv_prev_q;
  logic [3:0]  pre_cnt_q, pre_cnt_d;
  logic [7:0]  n_q, n_d, pay_cnt_q, pay_cnt_d;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [31:0] line_q, line_d, crc_q, crc_d;
  logic        sfd_seen_q, sfd_seen_d, gmii_er_q, gmii_er_d;
  logic        bad_pre_q, bad_pre_d, too_long_q, too_long_d;
  logic        busy_q, busy_d, valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic        done_q, done_d, crc_ok_q, crc_ok_d;
  logic [7:0]  data_q, data_d, len_q, len_d;
  logic [3:0]  err_q, err_d;
  logic [31:0] crc_fin;
  logic        fcs_match, trunc, runt;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Oldest byte in the delay line is FCS byte 0, which carries crc[7:0].
  assign crc_fin   = ~crc_q;
  assign fcs_match = (line_q == {crc_fin[7:0], crc_fin[15:8], crc_fin[23:16], crc_fin[31:24]});
  assign trunc     = byte_cnt_q < ({3'b0, n_q} + 11'd6);
  assign runt      = byte_cnt_q < RUNT_BYTES;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    n_d        = n_q;
    pay_cnt_d  = pay_cnt_q;
    byte_cnt_d = byte_cnt_q;
    line_d     = line_q;
    crc_d      = crc_q;
    sfd_seen_d = sfd_seen_q;
    gmii_er_d  = gmii_er_q;
    bad_pre_d  = bad_pre_q;
    too_long_d = too_long_q;
    valid_d    = 1'b0;
    sof_d      = 1'b0;
    eof_d      = 1'b0;
    done_d     = 1'b0;
    data_d     = data_q;
    len_d      = len_q;
    crc_ok_d   = crc_ok_q;
    err_d      = err_q;

    case (state_q)
      S_IDLE: begin
        if (dv_q && !dv_prev_q && rxd_q == 8'h55) begin
          state_d    = S_PREAMBLE;
          pre_cnt_d  = 4'd1;
          gmii_er_d  = er_q;
          bad_pre_d  = 1'b0;
          too_long_d = 1'b0;
        end
      end
      S_PREAMBLE: begin
        gmii_er_d = gmii_er_q | (dv_q & er_q);
        if (!dv_q) begin
          state_d   = S_DROP;
          bad_pre_d = 1'b1;
        end else if (rxd_q == 8'h55) begin
          if (pre_cnt_q != 4'hF) pre_cnt_d = pre_cnt_q + 4'd1;
        end else if (rxd_q == 8'hD5 && pre_cnt_q >= MIN_PRE) begin
          state_d    = S_CNTRL;
          sfd_seen_d = 1'b1;
          crc_d      = 32'hFFFFFFFF;
          byte_cnt_d = 11'd0;
          line_d     = 32'h0;
          pay_cnt_d  = 8'd0;
        end else begin
          state_d   = S_DROP;
          bad_pre_d = 1'b1;
        end
      end
      S_CNTRL, S_PAYLOAD, S_PAD: begin
        if (!dv_q) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          crc_ok_d = fcs_match && !trunc && !gmii_er_q;
          err_d    = {1'b0, trunc | runt, gmii_er_q, 1'b0};
        end else begin
          line_d     = {line_q[23:0], rxd_q};
          byte_cnt_d = byte_cnt_q + 11'd1;
          gmii_er_d  = gmii_er_q | er_q;
          if (byte_cnt_q >= 11'd4) crc_d = crc_byte(crc_q, line_q[31:24]);
          if (state_q == S_CNTRL) begin
            n_d     = rxd_q;
            state_d = S_PAYLOAD;
          end else if (state_q == S_PAYLOAD) begin
            valid_d = 1'b1;
            data_d  = rxd_q;
            sof_d   = (pay_cnt_q == 8'd0);
            if (pay_cnt_q == 8'd0) len_d = n_q;
            if (pay_cnt_q == n_q) begin
              eof_d   = 1'b1;
              state_d = S_PAD;
            end else begin
              pay_cnt_d = pay_cnt_q + 8'd1;
            end
          end
          // This byte pushes the post-SFD count past the limit.
          if (byte_cnt_q == MAX_BYTES) begin
            state_d    = S_DROP;
            too_long_d = 1'b1;
          end
        end
      end
      S_DROP: begin
        gmii_er_d = gmii_er_q | (dv_q & er_q);
        if (!dv_q) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          crc_ok_d = 1'b0;
          err_d    = {too_long_q, 1'b0, gmii_er_q, bad_pre_q};
        end
      end
      S_DONE: begin
        state_d    = S_IDLE;
        sfd_seen_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = sfd_seen_d;
  end

  always_ff @(posedge RX_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state_q    <= S_IDLE;
      rxd_q      <= 8'h0;
      dv_q       <= 1'b0;
      er_q       <= 1'b0;
      dv_prev_q  <= 1'b0;
      pre_cnt_q  <= 4'd0;
      n_q        <= 8'd0;
      pay_cnt_q  <= 8'd0;
      byte_cnt_q <= 11'd0;
      line_q     <= 32'h0;
      crc_q      <= 32'hFFFFFFFF;
      sfd_seen_q <= 1'b0;
      gmii_er_q  <= 1'b0;
      bad_pre_q  <= 1'b0;
      too_long_q <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      done_q     <= 1'b0;
      data_q     <= 8'h0;
      len_q      <= 8'h0;
      crc_ok_q   <= 1'b0;
      err_q      <= 4'h0;
    end else begin
      state_q    <= state_d;
      rxd_q      <= GMII_RXD;
      dv_q       <= GMII_RX_DV;
      er_q       <= GMII_RX_ER;
      dv_prev_q  <= dv_q;
      pre_cnt_q  <= pre_cnt_d;
      n_q        <= n_d;
      pay_cnt_q  <= pay_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      line_q     <= line_d;
      crc_q      <= crc_d;
      sfd_seen_q <= sfd_seen_d;
      gmii_er_q  <= gmii_er_d;
      bad_pre_q  <= bad_pre_d;
      too_long_q <= too_long_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      done_q     <= done_d;
      data_q     <= data_d;
      len_q      <= len_d;
      crc_ok_q   <= crc_ok_d;
      err_q      <= err_d;
    end
  end

  assign RX_BUSY   = busy_q;
  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign RX_SOF    = sof_q;
  assign RX_EOF    = eof_q;
  assign RX_LEN    = len_q;
  assign RX_DONE   = done_q;
  assign RX_CRC_OK = crc_ok_q;
  assign RX_ERR    = err_q;

endmodule
